// File: rtl/sprite_blitter.sv
// sprite_blitter: XOR-draws 8-pixel-wide sprites into a packed 1-bpp framebuffer
// at any pixel position, reports collisions, and clears the whole screen on request.
// Build option: define SPRITE_BLITTER_WRAP_EN to wrap sprites at the bottom and
// right screen edges instead of clipping them.
module sprite_blitter #(
   parameter logic [11:0] FB_BASE   = 12'h100,
   parameter int          ROW_BYTES = 8,
   parameter int          ROWS      = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        draw,
   input  logic        clear,
   input  logic [11:0] addr,
   input  logic [3:0]  lines,
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   output logic        busy,
   output logic        collision,
   output logic        mem_read,
   output logic [11:0] mem_read_idx,
   input  logic [7:0]  mem_read_byte,
   input  logic        mem_read_ack,
   output logic        mem_write,
   output logic [11:0] mem_write_idx,
   output logic [7:0]  mem_write_byte
);

   localparam int CW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int NB = ROW_BYTES * ROWS;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LD_SPR, S_LD_L, S_ST_L, S_LD_R, S_ST_R, S_CLR
   } state_t;

   state_t          r_state, w_next;
   logic [11:0]     r_spr_addr;
   logic [RW-1:0]   r_row;
   logic [CW-1:0]   r_col;
   logic [2:0]      r_sh;
   logic [3:0]      r_lines;
   logic [7:0]      r_spr;
   logic [7:0]      r_old;
   logic            r_collision;
   logic [IW-1:0]   r_clr_idx;

   logic [CW-1:0]   w_col0;
   logic [RW-1:0]   w_y0;
   logic [3:0]      w_count;
   logic [CW-1:0]   w_right_col;
   logic [11:0]     w_row_base;
   logic [11:0]     w_left_addr;
   logic [11:0]     w_right_addr;
   logic            w_has_right;
   logic [7:0]      w_pat_l;
   logic [15:0]     w_spr_ext;
   logic [7:0]      w_pat_r;
   logic            w_last_line;
   logic            w_clr_last;
   logic            w_unused_bits;

   // Start coordinates wrap onto the screen; the row pointer is kept as (row, col)
   // so that row wrap-around and column-0 wrap fall out of the counter widths.
   assign w_col0 = x[CW+2:3];
   assign w_y0   = y[RW-1:0];

`ifdef SPRITE_BLITTER_WRAP_EN
   assign w_count     = lines;
   assign w_has_right = (r_sh != 3'd0);
`else
   logic [8:0] w_avail;
   assign w_avail     = 9'(ROWS) - 9'(w_y0);
   assign w_count     = ({5'd0, lines} < w_avail) ? lines : w_avail[3:0];
   assign w_has_right = (r_sh != 3'd0) && (r_col != CW'(ROW_BYTES - 1));
`endif

   assign w_right_col  = r_col + CW'(1);
   assign w_row_base   = FB_BASE + (12'(r_row) << CW);
   assign w_left_addr  = w_row_base + 12'(r_col);
   assign w_right_addr = w_row_base + 12'(w_right_col);
   assign w_pat_l      = r_spr >> r_sh;
   // Low byte of {s,0}>>sh equals s<<(8-sh) truncated to 8 bits, without an 8-shift corner case.
   assign w_spr_ext    = {r_spr, 8'h00} >> r_sh;
   assign w_pat_r      = w_spr_ext[7:0];
   assign w_last_line  = (r_lines == 4'd1);
   assign w_clr_last   = (r_clr_idx == IW'(NB - 1));
   assign w_unused_bits = ^{x[7:CW+3], y[7:RW], w_spr_ext[15:8]};

   assign collision = r_collision;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and memory-interface decode; all mem_* outputs are 0 in IDLE.
   always_comb begin
      w_next         = r_state;
      busy           = (r_state != S_IDLE);
      mem_read       = 1'b0;
      mem_read_idx   = '0;
      mem_write      = 1'b0;
      mem_write_idx  = '0;
      mem_write_byte = '0;
      case (r_state)
         S_IDLE: begin
            if (clear)                         w_next = S_CLR;
            else if (draw && lines != 4'd0)    w_next = S_LD_SPR;
         end
         S_LD_SPR: begin
            mem_read     = !mem_read_ack;
            mem_read_idx = r_spr_addr;
            if (mem_read_ack) w_next = S_LD_L;
         end
         S_LD_L: begin
            mem_read     = !mem_read_ack;
            mem_read_idx = w_left_addr;
            if (mem_read_ack) w_next = S_ST_L;
         end
         S_ST_L: begin
            mem_write      = 1'b1;
            mem_write_idx  = w_left_addr;
            mem_write_byte = r_old ^ w_pat_l;
            if (w_has_right)      w_next = S_LD_R;
            else if (w_last_line) w_next = S_IDLE;
            else                  w_next = S_LD_SPR;
         end
         S_LD_R: begin
            mem_read     = !mem_read_ack;
            mem_read_idx = w_right_addr;
            if (mem_read_ack) w_next = S_ST_R;
         end
         S_ST_R: begin
            mem_write      = 1'b1;
            mem_write_idx  = w_right_addr;
            mem_write_byte = r_old ^ w_pat_r;
            w_next         = w_last_line ? S_IDLE : S_LD_SPR;
         end
         S_CLR: begin
            mem_write      = 1'b1;
            mem_write_idx  = FB_BASE + 12'(r_clr_idx);
            mem_write_byte = 8'h00;
            if (w_clr_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: command latch, sprite/old-byte capture, line stepping, collision, clear index.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_spr_addr  <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_sh        <= '0;
         r_lines     <= '0;
         r_spr       <= '0;
         r_old       <= '0;
         r_collision <= 1'b0;
         r_clr_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (clear) begin
                  r_collision <= 1'b0;
                  r_clr_idx   <= '0;
               end else if (draw) begin
                  r_collision <= 1'b0;
                  if (lines != 4'd0) begin
                     r_spr_addr <= addr;
                     r_row      <= w_y0;
                     r_col      <= w_col0;
                     r_sh       <= x[2:0];
                     r_lines    <= w_count;
                  end
               end
            end
            S_LD_SPR: if (mem_read_ack) r_spr <= mem_read_byte;
            S_LD_L, S_LD_R: if (mem_read_ack) r_old <= mem_read_byte;
            S_ST_L: begin
               if ((r_old & w_pat_l) != 8'h00) r_collision <= 1'b1;
               if (!w_has_right && !w_last_line) begin
                  r_spr_addr <= r_spr_addr + 12'd1;
                  r_row      <= r_row + RW'(1);
                  r_lines    <= r_lines - 4'd1;
               end
            end
            S_ST_R: begin
               if ((r_old & w_pat_r) != 8'h00) r_collision <= 1'b1;
               if (!w_last_line) begin
                  r_spr_addr <= r_spr_addr + 12'd1;
                  r_row      <= r_row + RW'(1);
                  r_lines    <= r_lines - 4'd1;
               end
            end
            S_CLR: r_clr_idx <= r_clr_idx + IW'(1);
            default: ;
         endcase
      end
   end

endmodule
